// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline flow controller.
//   PC_SEL_*   : encodings of the PC source mux select
//   HANDLER_PC : exception handler entry address
//   RESET_PC   : first fetch address after reset
//   fc_state_e : flow-controller FSM states
package cpu_pkg;

  localparam logic [1:0] PC_SEL_SEQ     = 2'd0;
  localparam logic [1:0] PC_SEL_HANDLER = 2'd1;
  localparam logic [1:0] PC_SEL_EPC     = 2'd2;
  localparam logic [1:0] PC_SEL_HOLD    = 2'd3;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;

  typedef enum logic {
    StRun,
    StMdWait
  } fc_state_e;

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide occupancy counter.
//   clk, reset     : clock, synchronous active-high reset
//   load_i         : an MD operation is accepted this cycle
//   is_div_i       : the accepted operation is a divide
//   cnt_o          : remaining busy cycles after the start cycle
//   busy_o         : MD unit occupied (start cycle or counter nonzero)
//   proto_err_o    : sticky flag, an operation was accepted while still busy
module md_busy_counter #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             is_div_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             busy_o,
  output logic             proto_err_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             proto_err_d, proto_err_q;

  always_comb begin
    cnt_d       = cnt_q;
    proto_err_d = proto_err_q;
    if (load_i) begin
      // A new start always reloads; overlapping an active op is a protocol error.
      cnt_d = is_div_i ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
      if (cnt_q != '0) begin
        proto_err_d = 1'b1;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign busy_o      = load_i | (cnt_q != '0);
  assign proto_err_o = proto_err_q;

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Central flow controller of the 5-stage pipeline.
// Inputs : clk, reset (sync, active-high), hz_stall_i, md_use_d_i, md_start_i, md_is_div_i,
//          exc_req_i, eret_d_i, epc_hz_i.
// Outputs: pc_en_o, if_id_en_o, id_ex_clr_o, flush_req_o, eret_flush_o, pc_sel_o[1:0],
//          md_start_ok_o, md_busy_o, proto_err_o.
// Priority each cycle: reset > exception > eret redirect > stall > normal flow.
module pipe_flow_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hz_stall_i,
  input  logic       md_use_d_i,
  input  logic       md_start_i,
  input  logic       md_is_div_i,
  input  logic       exc_req_i,
  input  logic       eret_d_i,
  input  logic       epc_hz_i,
  output logic       pc_en_o,
  output logic       if_id_en_o,
  output logic       id_ex_clr_o,
  output logic       flush_req_o,
  output logic       eret_flush_o,
  output logic [1:0] pc_sel_o,
  output logic       md_start_ok_o,
  output logic       md_busy_o,
  output logic       proto_err_o
);

  fc_state_e        state_q;
  logic [CNT_W-1:0] md_cnt;
  logic             cnt_busy;
  logic             md_start_ok;
  logic             stall;
  logic             eret_go;

  // The E-stage instruction is killed by an exception flush, so its MD start must not land.
  assign md_start_ok = md_start_i & ~exc_req_i & ~reset;

  md_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md_cnt (
    .clk         (clk),
    .reset       (reset),
    .load_i      (md_start_ok),
    .is_div_i    (md_is_div_i),
    .cnt_o       (md_cnt),
    .busy_o      (cnt_busy),
    .proto_err_o (proto_err_o)
  );

  assign md_start_ok_o = md_start_ok;
  assign md_busy_o     = cnt_busy & ~reset;

  assign stall   = hz_stall_i | (md_use_d_i & md_busy_o) | (eret_d_i & epc_hz_i);
  assign eret_go = eret_d_i & ~epc_hz_i & ~exc_req_i;

  // MDWAIT tracks an in-flight MD op; an exception does not abort it since HI/LO still commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      unique case (state_q)
        StRun:    if (md_start_ok) state_q <= StMdWait;
        StMdWait: if (md_cnt == CNT_W'(1) && !md_start_ok) state_q <= StRun;
        default:  state_q <= StRun;
      endcase
    end
  end

  always_comb begin
    pc_en_o      = 1'b1;
    if_id_en_o   = 1'b1;
    id_ex_clr_o  = 1'b0;
    flush_req_o  = 1'b0;
    eret_flush_o = 1'b0;
    pc_sel_o     = PC_SEL_SEQ;
    if (reset) begin
      // Hold the normal-flow defaults.
    end else if (exc_req_i) begin
      // The req path clears every stage, so no separate bubble is needed.
      flush_req_o = 1'b1;
      pc_sel_o    = PC_SEL_HANDLER;
    end else if (eret_go) begin
      eret_flush_o = 1'b1;
      pc_sel_o     = PC_SEL_EPC;
    end else if (stall) begin
      pc_en_o     = 1'b0;
      if_id_en_o  = 1'b0;
      id_ex_clr_o = 1'b1;
      pc_sel_o    = PC_SEL_HOLD;
    end
  end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Self-checking bench for pipe_flow_ctrl: per-cycle scoreboard of all outputs plus directed checks.
module tb_pipe_flow_ctrl;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset, hz_stall, md_use_d, md_start, md_is_div, exc_req, eret_d, epc_hz;
  logic       pc_en, if_id_en, id_ex_clr, flush_req, eret_flush, md_start_ok, md_busy, proto_err;
  logic [1:0] pc_sel;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [9:0] sb_q[$];
  string      tag_q[$];
  logic [9:0] obs;
  int         m_cnt  = 0;
  logic       m_perr = 1'b0;

  always #5 clk = ~clk;

  pipe_flow_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .hz_stall_i    (hz_stall),
    .md_use_d_i    (md_use_d),
    .md_start_i    (md_start),
    .md_is_div_i   (md_is_div),
    .exc_req_i     (exc_req),
    .eret_d_i      (eret_d),
    .epc_hz_i      (epc_hz),
    .pc_en_o       (pc_en),
    .if_id_en_o    (if_id_en),
    .id_ex_clr_o   (id_ex_clr),
    .flush_req_o   (flush_req),
    .eret_flush_o  (eret_flush),
    .pc_sel_o      (pc_sel),
    .md_start_ok_o (md_start_ok),
    .md_busy_o     (md_busy),
    .proto_err_o   (proto_err)
  );

  // Expected packing: {pc_en, if_id_en, id_ex_clr, flush_req, eret_flush, pc_sel, ok, busy, perr}
  function automatic logic [9:0] model_out(input logic rst, input logic hz, input logic use_d,
                                           input logic st, input logic exc, input logic eret,
                                           input logic epch);
    logic ok, busy, stl, go, pe, ie, clr, fl, ef;
    logic [1:0] sel;
    ok   = st & ~exc & ~rst;
    busy = ~rst & (ok | (m_cnt != 0));
    stl  = hz | (use_d & busy) | (eret & epch);
    go   = eret & ~epch & ~exc;
    pe = 1'b1; ie = 1'b1; clr = 1'b0; fl = 1'b0; ef = 1'b0; sel = 2'd0;
    if (rst) begin
      sel = 2'd0;
    end else if (exc) begin
      fl = 1'b1; sel = 2'd1;
    end else if (go) begin
      ef = 1'b1; sel = 2'd2;
    end else if (stl) begin
      pe = 1'b0; ie = 1'b0; clr = 1'b1; sel = 2'd3;
    end
    return {pe, ie, clr, fl, ef, sel, ok, busy, m_perr};
  endfunction

  task automatic step(input logic rst, input logic hz, input logic use_d, input logic st,
                      input logic div, input logic exc, input logic eret, input logic epch,
                      input string tag);
    logic [9:0] exp;
    string      t;
    logic       ok;
    reset = rst; hz_stall = hz; md_use_d = use_d; md_start = st; md_is_div = div;
    exc_req = exc; eret_d = eret; epc_hz = epch;
    sb_q.push_back(model_out(rst, hz, use_d, st, exc, eret, epch));
    tag_q.push_back(tag);
    @(negedge clk);
    obs = {pc_en, if_id_en, id_ex_clr, flush_req, eret_flush, pc_sel, md_start_ok, md_busy,
           proto_err};
    exp = sb_q.pop_front();
    t   = tag_q.pop_front();
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", t, obs, exp);
    end
    @(posedge clk);
    ok = st & ~exc & ~rst;
    if (rst) begin
      m_cnt = 0; m_perr = 1'b0;
    end else if (ok) begin
      if (m_cnt != 0) m_perr = 1'b1;
      m_cnt = div ? 10 : 5;
    end else if (m_cnt != 0) begin
      m_cnt--;
    end
    #1;
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; hz_stall = 1'b0; md_use_d = 1'b0; md_start = 1'b0; md_is_div = 1'b0;
    exc_req = 1'b0; eret_d = 1'b0; epc_hz = 1'b0;
    @(posedge clk);
    #1;

    // Outputs while reset is held, including a start request that must be suppressed.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_hold");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "reset_with_reqs");
    chk("reset_state", int'(dut.state_q), int'(StRun));

    // 1: quiet pipeline.
    for (int i = 0; i < 10; i++) idle("idle");
    chk("idle_pc_en", int'(obs[9]), 1);

    // 2: mult then div with the consumer waiting in D.
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b1, i == 0, 1'b0, 1'b0, 1'b0, 1'b0, "mult_stall");
      chk("mult_pc_sel", int'(obs[4:3]), (i < 6) ? 3 : 0);
      if (i == 1) chk("mult_mdwait", int'(dut.state_q), int'(StMdWait));
    end
    chk("mult_back_to_run", int'(dut.state_q), int'(StRun));
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b1, i == 0, 1'b1, 1'b0, 1'b0, 1'b0, "div_stall");
      chk("div_id_ex_clr", int'(obs[7]), (i < 11) ? 1 : 0);
    end

    // 3: exception during a hazard stall inside MDWAIT; MD op still finishes on time.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "exc_mult_start");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "exc_over_stall");
    chk("exc_flush", int'(obs[6]), 1);
    chk("exc_no_bubble", int'(obs[7]), 0);
    chk("exc_pc_sel", int'(obs[4:3]), 1);
    for (int i = 2; i < 7; i++) begin
      idle("exc_md_drain");
      chk("exc_md_busy", int'(obs[1]), (i < 6) ? 1 : 0);
    end

    // 4: eret waits for EPC to settle, then redirects once.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "eret_epc_hz0");
    chk("eret_hold0", int'(obs[4:3]), 3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "eret_epc_hz1");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "eret_go");
    chk("eret_flush", int'(obs[5]), 1);
    chk("eret_pc_sel", int'(obs[4:3]), 2);
    idle("eret_after");
    chk("eret_once", int'(obs[5]), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "exc_over_eret");
    chk("exc_over_eret_sel", int'(obs[4:3]), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "eret_over_hz");

    // 5: start killed by a same-cycle exception.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "start_killed");
    chk("killed_start_ok", int'(obs[2]), 0);
    idle("start_killed_after");
    chk("killed_busy", int'(obs[1]), 0);

    // 6: reset in the middle of a divide, then overlapping starts.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "div_for_reset");
    idle("div_for_reset_1");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_mid_div");
    idle("after_reset");
    chk("after_reset_busy", int'(obs[1]), 0);
    chk("after_reset_state", int'(dut.state_q), int'(StRun));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "proto_first");
    idle("proto_gap");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "proto_overlap");
    chk("proto_not_yet", int'(obs[0]), 0);
    for (int i = 0; i < 12; i++) idle("proto_sticky");
    chk("proto_sticky_end", int'(obs[0]), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "proto_reset");
    idle("proto_cleared");
    chk("proto_cleared_bit", int'(obs[0]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
